// File: rtl/pipeline_stall_controller_pkg.sv
// rtl/pipeline_stall_controller_pkg.sv - shared state encodings and stage-control vectors for the pipeline sequencer
package pipeline_stall_controller_pkg;

  localparam int CTRL_ST_W = 2;

  typedef enum logic [CTRL_ST_W-1:0] {
    CTRL_ST_RUN        = 2'd0,
    CTRL_ST_MEM_WAIT   = 2'd1,
    CTRL_ST_REDIR_PEND = 2'd2,
    CTRL_ST_HALT       = 2'd3
  } ctrl_state_e;

  typedef struct packed {
    logic pc_we;
    logic if_id_we;
    logic if_id_flush;
    logic id_ex_we;
    logic id_ex_flush;
    logic ex_mem_we;
    logic mem_wb_we;
    logic pc_sel_redirect;
  } stage_ctrl_t;

  // Field order: pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, mem_wb_we, pc_sel_redirect
  localparam stage_ctrl_t CTRL_IN_RESET     = 8'b0010_1000;
  localparam stage_ctrl_t CTRL_FREEZE       = 8'b0000_0000;
  localparam stage_ctrl_t CTRL_FLOW         = 8'b1101_0110;
  localparam stage_ctrl_t CTRL_REDIRECT     = 8'b1111_1111;
  localparam stage_ctrl_t CTRL_REDIR_DEFER  = 8'b0011_1110;
  localparam stage_ctrl_t CTRL_LOAD_USE     = 8'b0001_1110;
  localparam stage_ctrl_t CTRL_FETCH_WAIT   = 8'b0011_0110;
  localparam stage_ctrl_t CTRL_PEND_FROZEN  = 8'b0010_0000;
  localparam stage_ctrl_t CTRL_PEND_RELEASE = 8'b1011_0111;

endpackage

// File: rtl/stall_perf_counters.sv
// rtl/stall_perf_counters.sv - free-running 32-bit stall, redirect and memory-wait event counters
module stall_perf_counters (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_inc_i,
  input  logic        flush_inc_i,
  input  logic        memwait_inc_i,
  output logic [31:0] stall_cycles_o,
  output logic [31:0] flush_count_o,
  output logic [31:0] memwait_cycles_o
);

  logic [31:0] stall_q;
  logic [31:0] flush_q;
  logic [31:0] memwait_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q   <= '0;
      flush_q   <= '0;
      memwait_q <= '0;
    end else begin
      if (stall_inc_i)   stall_q   <= stall_q + 32'd1;
      if (flush_inc_i)   flush_q   <= flush_q + 32'd1;
      if (memwait_inc_i) memwait_q <= memwait_q + 32'd1;
    end
  end

  assign stall_cycles_o   = stall_q;
  assign flush_count_o    = flush_q;
  assign memwait_cycles_o = memwait_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// rtl/pipeline_stall_controller.sv - 5-stage pipeline stall/flush sequencer with dmem watchdog
// Optional perf counters under STALL_PERF_CNT_EN.
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int unsigned MAX_MEM_WAIT = 16,
  parameter int unsigned WAIT_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_use_stall,
  input  logic                 branch_taken,
  input  logic                 imem_busy,
  input  logic                 dmem_busy,
  input  logic                 halt_req,
  output logic                 pc_we,
  output logic                 if_id_we,
  output logic                 if_id_flush,
  output logic                 id_ex_we,
  output logic                 id_ex_flush,
  output logic                 ex_mem_we,
  output logic                 mem_wb_we,
  output logic                 pc_sel_redirect,
  output logic                 halted,
  output logic                 mem_timeout,
  output logic [CTRL_ST_W-1:0] ctrl_state
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [31:0]          perf_stall_cycles,
  output logic [31:0]          perf_flush_count,
  output logic [31:0]          perf_memwait_cycles
`endif
);

  localparam logic [WAIT_CNT_W-1:0] MAX_CNT = WAIT_CNT_W'(MAX_MEM_WAIT);

  ctrl_state_e            state_q, state_d;
  logic [WAIT_CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic                   halted_q;
  logic                   timeout_q, timeout_d;
  stage_ctrl_t            ctrl;

  assign cnt_inc = (cnt_q >= MAX_CNT) ? MAX_CNT : cnt_q + WAIT_CNT_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CTRL_ST_RUN;
      cnt_q     <= '0;
      halted_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      halted_q  <= (state_d == CTRL_ST_HALT);
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    unique case (state_q)
      CTRL_ST_RUN: begin
        if (halt_req) begin
          state_d = CTRL_ST_HALT;
        end else if (dmem_busy) begin
          state_d = CTRL_ST_MEM_WAIT;
          cnt_d   = WAIT_CNT_W'(1);
        end else if (branch_taken && imem_busy) begin
          state_d = CTRL_ST_REDIR_PEND;
        end
      end
      CTRL_ST_MEM_WAIT: begin
        // halt_req is ignored here: WB is frozen, so the request re-presents later
        if (!dmem_busy) begin
          state_d = CTRL_ST_RUN;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= MAX_CNT) begin
            timeout_d = 1'b1;
            state_d   = CTRL_ST_HALT;
          end
        end
      end
      CTRL_ST_REDIR_PEND: begin
        if (halt_req) begin
          state_d = CTRL_ST_HALT;
        end else if (!dmem_busy && !imem_busy) begin
          state_d = CTRL_ST_RUN;
        end
      end
      CTRL_ST_HALT: begin
        state_d = CTRL_ST_HALT;
      end
      default: begin
        state_d = CTRL_ST_RUN;
      end
    endcase
    if (state_d == CTRL_ST_RUN) cnt_d = '0;
  end

  always_comb begin
    ctrl = CTRL_FREEZE;
    if (rst) begin
      ctrl = CTRL_IN_RESET;
    end else begin
      unique case (state_q)
        CTRL_ST_RUN: begin
          if (halt_req || dmem_busy)  ctrl = CTRL_FREEZE;
          else if (branch_taken)      ctrl = imem_busy ? CTRL_REDIR_DEFER : CTRL_REDIRECT;
          else if (load_use_stall)    ctrl = CTRL_LOAD_USE;
          else if (imem_busy)         ctrl = CTRL_FETCH_WAIT;
          else                        ctrl = CTRL_FLOW;
        end
        CTRL_ST_MEM_WAIT: begin
          ctrl = dmem_busy ? CTRL_FREEZE : CTRL_FLOW;
        end
        CTRL_ST_REDIR_PEND: begin
          if (halt_req)        ctrl = CTRL_FREEZE;
          else if (dmem_busy)  ctrl = CTRL_PEND_FROZEN;
          else if (imem_busy)  ctrl = CTRL_FETCH_WAIT;
          else                 ctrl = CTRL_PEND_RELEASE;
        end
        CTRL_ST_HALT: begin
          ctrl = CTRL_FREEZE;
        end
        default: begin
          ctrl = CTRL_FREEZE;
        end
      endcase
    end
  end

  assign pc_we           = ctrl.pc_we;
  assign if_id_we        = ctrl.if_id_we;
  assign if_id_flush     = ctrl.if_id_flush;
  assign id_ex_we        = ctrl.id_ex_we;
  assign id_ex_flush     = ctrl.id_ex_flush;
  assign ex_mem_we       = ctrl.ex_mem_we;
  assign mem_wb_we       = ctrl.mem_wb_we;
  assign pc_sel_redirect = ctrl.pc_sel_redirect;
  assign halted          = halted_q;
  assign mem_timeout     = timeout_q;
  assign ctrl_state      = state_q;

`ifdef STALL_PERF_CNT_EN
  stall_perf_counters u_perf (
    .clk_i            (clk),
    .rst_i            (rst),
    .stall_inc_i      (!rst && !ctrl.pc_we && (state_q != CTRL_ST_HALT)),
    .flush_inc_i      (ctrl.pc_sel_redirect),
    .memwait_inc_i    (!rst && (state_q == CTRL_ST_MEM_WAIT)),
    .stall_cycles_o   (perf_stall_cycles),
    .flush_count_o    (perf_flush_count),
    .memwait_cycles_o (perf_memwait_cycles)
  );
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb/tb_pipeline_stall_controller.sv - directed bench for pipeline_stall_controller against a flag-based model
module tb_pipeline_stall_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, lu, br, im, dm, hr;
  logic [1:0] pc_we_w, if_id_we_w, if_id_flush_w, id_ex_we_w, id_ex_flush_w;
  logic [1:0] ex_mem_we_w, mem_wb_we_w, pc_sel_w, halted_w, timeout_w;
  logic [1:0] st_w [2];

  // Instance 0 uses the default watchdog limit, instance 1 a short limit of 4.
  for (genvar g = 0; g < 2; g++) begin : g_dut
`ifdef STALL_PERF_CNT_EN
    logic [31:0] perf_s, perf_f, perf_m;
`endif
    pipeline_stall_controller #(.MAX_MEM_WAIT(g == 0 ? 16 : 4), .WAIT_CNT_W(8)) u_dut (
      .clk             (clk),
      .rst             (rst),
      .load_use_stall  (lu),
      .branch_taken    (br),
      .imem_busy       (im),
      .dmem_busy       (dm),
      .halt_req        (hr),
      .pc_we           (pc_we_w[g]),
      .if_id_we        (if_id_we_w[g]),
      .if_id_flush     (if_id_flush_w[g]),
      .id_ex_we        (id_ex_we_w[g]),
      .id_ex_flush     (id_ex_flush_w[g]),
      .ex_mem_we       (ex_mem_we_w[g]),
      .mem_wb_we       (mem_wb_we_w[g]),
      .pc_sel_redirect (pc_sel_w[g]),
      .halted          (halted_w[g]),
      .mem_timeout     (timeout_w[g]),
      .ctrl_state      (st_w[g])
`ifdef STALL_PERF_CNT_EN
      ,
      .perf_stall_cycles   (perf_s),
      .perf_flush_count    (perf_f),
      .perf_memwait_cycles (perf_m)
`endif
    );
  end

  int n_vec = 0;
  int n_bad = 0;

  int  maxw  [2] = '{16, 4};
  bit  m_halt[2], m_mw[2], m_rd[2], m_to[2];
  int  m_cnt [2];

  logic [7:0] s_ctrl[2];
  logic [1:0] s_st  [2];
  logic       s_hl  [2], s_to[2];

  task automatic chk(input string name, input int k, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[u%0d] @%0t: got %b, expected %b", name, k, $time, act, exp);
    end
  endtask

  // Output bundle order: pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we, mem_wb_we, pc_sel
  function automatic logic [7:0] exp_ctrl(int k);
    if (rst)       return 8'b0010_1000;
    if (m_halt[k]) return 8'h00;
    if (m_mw[k])   return dm ? 8'h00 : 8'b1101_0110;
    if (m_rd[k]) begin
      if (hr) return 8'h00;
      if (dm) return 8'b0010_0000;
      if (im) return 8'b0011_0110;
      return 8'b1011_0111;
    end
    if (hr || dm) return 8'h00;
    if (br)       return im ? 8'b0011_1110 : 8'b1111_1111;
    if (lu)       return 8'b0001_1110;
    if (im)       return 8'b0011_0110;
    return 8'b1101_0110;
  endfunction

  function automatic logic [1:0] exp_state(int k);
    if (m_halt[k]) return 2'd3;
    if (m_mw[k])   return 2'd1;
    if (m_rd[k])   return 2'd2;
    return 2'd0;
  endfunction

  task automatic model_advance(int k);
    if (rst) begin
      m_halt[k] = 0; m_mw[k] = 0; m_rd[k] = 0; m_to[k] = 0; m_cnt[k] = 0;
    end else if (m_halt[k]) begin
      m_halt[k] = 1;
    end else if (m_mw[k]) begin
      if (!dm) begin
        m_mw[k] = 0; m_cnt[k] = 0;
      end else begin
        m_cnt[k] = (m_cnt[k] + 1 > maxw[k]) ? maxw[k] : m_cnt[k] + 1;
        if (m_cnt[k] >= maxw[k]) begin
          m_to[k] = 1; m_halt[k] = 1; m_mw[k] = 0;
        end
      end
    end else if (m_rd[k]) begin
      if (hr) begin
        m_halt[k] = 1; m_rd[k] = 0;
      end else if (!dm && !im) begin
        m_rd[k] = 0;
      end
    end else begin
      if (hr)              m_halt[k] = 1;
      else if (dm)         begin m_mw[k] = 1; m_cnt[k] = 1; end
      else if (br && im)   m_rd[k] = 1;
    end
  endtask

  task automatic step(input bit r, input bit l, input bit b, input bit i, input bit d, input bit h);
    rst = r; lu = l; br = b; im = i; dm = d; hr = h;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      s_ctrl[k] = {pc_we_w[k], if_id_we_w[k], if_id_flush_w[k], id_ex_we_w[k], id_ex_flush_w[k],
                   ex_mem_we_w[k], mem_wb_we_w[k], pc_sel_w[k]};
      s_st[k] = st_w[k];
      s_hl[k] = halted_w[k];
      s_to[k] = timeout_w[k];
      chk("ctrl", k, s_ctrl[k], exp_ctrl(k));
      chk("state", k, {6'd0, s_st[k]}, {6'd0, exp_state(k)});
      chk("halted", k, {7'd0, s_hl[k]}, {7'd0, m_halt[k]});
      chk("timeout", k, {7'd0, s_to[k]}, {7'd0, m_to[k]});
      model_advance(k);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1; lu = 0; br = 0; im = 0; dm = 0; hr = 0;
    @(posedge clk);
    #1;

    // reset held 3 cycles
    repeat (3) do_reset();
    chk("lit_reset_ctrl", 0, s_ctrl[0], 8'b0010_1000);
    idle();
    chk("lit_run_ctrl", 0, s_ctrl[0], 8'b1101_0110);
    chk("lit_run_state", 0, {6'd0, s_st[0]}, 8'd0);

    // load-use bubble
    step(0, 1, 0, 0, 0, 0);
    chk("lit_loaduse", 0, s_ctrl[0], 8'b0001_1110);
    idle();
    chk("lit_after_lu", 0, s_ctrl[0], 8'b1101_0110);

    // immediate redirect, with load-use overridden
    step(0, 1, 1, 0, 0, 0);
    chk("lit_redirect", 0, s_ctrl[0], 8'b1111_1111);

    // redirect deferred by fetch wait
    step(0, 0, 1, 1, 0, 0);
    chk("lit_defer", 0, s_ctrl[0], 8'b0011_1110);
    step(0, 0, 0, 1, 0, 0);
    chk("lit_pend_state", 0, {6'd0, s_st[0]}, 8'd2);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("lit_pend_release", 0, s_ctrl[0], 8'b1011_0111);
    idle();
    chk("lit_back_run", 0, {6'd0, s_st[0]}, 8'd0);

    // pending redirect frozen by dmem, then released
    step(0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    chk("lit_pend_frozen", 0, s_ctrl[0], 8'b0010_0000);
    step(0, 0, 0, 0, 0, 0);
    idle();

    // memory wait swallows a simultaneous branch
    step(0, 0, 1, 0, 1, 0);
    chk("lit_mw_enter", 0, s_ctrl[0], 8'h00);
    repeat (3) step(0, 0, 0, 0, 1, 0);
    chk("lit_mw_state", 0, {6'd0, s_st[0]}, 8'd1);
    step(0, 0, 0, 0, 0, 0);
    chk("lit_mw_release", 0, s_ctrl[0], 8'b1101_0110);
    idle();
    chk("lit_mw_run", 0, {6'd0, s_st[0]}, 8'd0);
    do_reset();

    // halt_req is ignored while waiting on memory
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 0, 0, 0);
    chk("lit_mw_nohalt", 0, {6'd0, s_st[0]}, 8'd1);
    idle();
    do_reset();

    // watchdog on the short-limit instance
    repeat (4) step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    chk("lit_wd_state", 1, {6'd0, s_st[1]}, 8'd3);
    chk("lit_wd_timeout", 1, {7'd0, s_to[1]}, 8'd1);
    chk("lit_wd_long_ok", 0, {7'd0, s_to[0]}, 8'd0);
    repeat (2) step(0, 0, 0, 0, 0, 0);
    chk("lit_wd_sticky", 1, {7'd0, s_to[1]}, 8'd1);
    do_reset();
    idle();
    chk("lit_wd_cleared", 1, {7'd0, s_to[1]}, 8'd0);

    // halt beats load-use
    step(0, 1, 0, 0, 0, 1);
    chk("lit_halt_ctrl", 0, s_ctrl[0], 8'h00);
    step(0, 1, 0, 0, 0, 0);
    chk("lit_halted", 0, {7'd0, s_hl[0]}, 8'd1);
    repeat (2) idle();
    chk("lit_halt_pcwe", 0, {7'd0, s_ctrl[0][7]}, 8'd0);
    do_reset();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Central sequencer for the 5-stage RV32 pipeline.
- Merges the load-use stall request, EX-stage branch/jump redirect, instruction/data memory busy signals and halt request.
- Drives the per-stage write enables and flushes for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Holds a small FSM for multi-cycle memory waits, deferred redirects and halt; includes a data-memory wait watchdog.

Parameters:
- MAX_MEM_WAIT, 16, max consecutive dmem_busy cycles before timeout (1..255).
- WAIT_CNT_W, 8, width of the wait counter; must hold MAX_MEM_WAIT.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- load_use_stall  in  1  load-use hazard request from ID
- branch_taken  in  1  EX resolved taken branch/jump; redirect target is valid this cycle
- imem_busy  in  1  instruction fetch not complete this cycle
- dmem_busy  in  1  data access in MEM not complete this cycle
- halt_req  in  1  ebreak/ecall retiring in WB
- pc_we  out  1  PC register write enable
- if_id_we  out  1  IF/ID write enable
- if_id_flush  out  1  IF/ID insert bubble
- id_ex_we  out  1  ID/EX write enable
- id_ex_flush  out  1  ID/EX insert bubble
- ex_mem_we  out  1  EX/MEM write enable
- mem_wb_we  out  1  MEM/WB write enable
- pc_sel_redirect  out  1  PC mux selects redirect target
- halted  out  1  core halted (registered)
- mem_timeout  out  1  sticky watchdog error (registered)
- ctrl_state  out  2  current FSM state

Behaviour:
- States: RUN=0, MEM_WAIT=1, REDIR_PEND=2, HALT=3. Encodings live in the shared package.
- Reset: state=RUN, wait counter=0, halted=0, mem_timeout=0.
- While rst=1, all _we outputs=0, both flushes=1, pc_sel_redirect=0.
- Stage controls are combinational from state and inputs (zero latency). halted, mem_timeout and ctrl_state are registered.
- Per-cycle priority: halt_req > dmem_busy > branch_taken > load_use_stall > imem_busy.
- RUN, no events: all _we=1, flushes=0.
- RUN, halt_req: all _we=0; next state HALT; halted=1 from the next cycle.
- RUN, dmem_busy: freeze. All _we=0, no flush, counter starts at 1; next state MEM_WAIT.
  - A branch_taken in the same cycle is dropped. EX is held frozen, so the branch re-presents when released.
- RUN, branch_taken with imem_busy=0: pc_sel_redirect=1, pc_we=1, if_id_flush=1, id_ex_flush=1, other _we=1. The flush overrides any load_use_stall.
- RUN, branch_taken with imem_busy=1: pc_we=0, if_id_flush=1, id_ex_flush=1, ex_mem_we=1, mem_wb_we=1. Next state REDIR_PEND.
- RUN, load_use_stall: pc_we=0, if_id_we=0, id_ex_flush=1, ex_mem_we=1, mem_wb_we=1.
- RUN, imem_busy only: pc_we=0, if_id_we=0, if_id_flush=1, downstream _we=1.
- MEM_WAIT: all _we=0; counter increments each cycle dmem_busy=1.
  - dmem_busy=0: release to RUN; this cycle all _we=1 (the MEM result is captured).
  - Counter reaches MAX_MEM_WAIT with dmem_busy still 1: mem_timeout set (sticky until reset); next state HALT.
  - halt_req is ignored in MEM_WAIT; WB is frozen.
- REDIR_PEND: holds the redirect until imem_busy=0.
  - While waiting: pc_we=0, if_id_flush=1, no other flush asserted; downstream _we=1 unless dmem_busy=1, which freezes them and stays in REDIR_PEND.
  - When imem_busy=0: pc_sel_redirect=1, pc_we=1 for one cycle; next state RUN.
  - The redirect target is assumed held by the EX/MEM-side redirect register outside this block.
- HALT: all _we=0, no flush, halted=1. Exit only via rst.
- Counter saturates at MAX_MEM_WAIT and clears on entry to RUN.

Optional Feature:
- Macro: STALL_PERF_CNT_EN.
- When defined, adds outputs perf_stall_cycles[31:0], perf_flush_count[31:0] and perf_memwait_cycles[31:0].
  - Counters reset to 0 and wrap at 2^32.
  - perf_stall_cycles increments each cycle pc_we=0 outside HALT.
  - perf_flush_count increments per redirect taken.
  - perf_memwait_cycles increments each MEM_WAIT cycle.
- When undefined: no ports, no logic; other behaviour is identical.

Decomposition:
- Shared package/header (alongside the core constants): the state encodings CTRL_ST_RUN / CTRL_ST_MEM_WAIT / CTRL_ST_REDIR_PEND / CTRL_ST_HALT, and the 2-bit state width.
- One sub-module, stall_perf_counters, instantiated only under STALL_PERF_CNT_EN.

Test Plan:
- Reset behaviour: rst held 3 cycles → all _we=0, flushes=1; after release, ctrl_state=0, pc_we=1, halted=0, mem_timeout=0.
- Load-use stall: load_use_stall=1 for 1 cycle in RUN → pc_we=0, if_id_we=0, id_ex_flush=1, ex_mem_we=1; next cycle all _we=1.
- Branch during fetch wait: branch_taken=1 with imem_busy=1, then imem_busy held 2 more cycles → ctrl_state=2 for those cycles; on the imem_busy=0 cycle pc_sel_redirect=1 and pc_we=1, then ctrl_state=0.
- Memory wait vs. branch: dmem_busy=1 for 4 cycles with branch_taken=1 on the first → all _we=0 for 4 cycles, no flush; release cycle all _we=1, ctrl_state back to 0.
- Watchdog timeout: MAX_MEM_WAIT=4, dmem_busy stuck at 1 → mem_timeout=1 and ctrl_state=3 after the 4th wait cycle; both stay set until rst.
- Halt vs. stall: halt_req=1 with load_use_stall=1 in the same cycle → halt wins; halted=1 next cycle; pc_we stays 0 thereafter.
